// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-index type, writeback source enum and x0 constant
package riscv_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_src_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester arbiter (ALU vs load) with fixed-priority or round-robin mode
module rr_arbiter2
  import riscv_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_AluReq,
  input  logic i_LoadReq,
  input  logic i_LoadPriority,
  output logic o_AluGrant,
  output logic o_LoadGrant
);

  wb_src_t lastGrant;
  logic    contended;

  assign contended = i_AluReq & i_LoadReq;

  // Lone requester always wins; on contention pick load if forced, else whoever lost last time
  always_comb begin
    o_AluGrant  = 1'b0;
    o_LoadGrant = 1'b0;
    if (contended) begin
      if (i_LoadPriority || (lastGrant == WB_ALU)) begin
        o_LoadGrant = 1'b1;
      end else begin
        o_AluGrant = 1'b1;
      end
    end else begin
      o_AluGrant  = i_AluReq;
      o_LoadGrant = i_LoadReq;
    end
  end

  // Pointer remembers only contended winners; reset value makes load the first favourite
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      lastGrant <= WB_ALU;
    end else if (contended) begin
      lastGrant <= o_LoadGrant ? WB_LOAD : WB_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register file write port between ALU and load writeback with hazard scoreboard
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_PRIORITY  = 0
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_AluValid,
  input  logic [REG_ADDR_WIDTH-1:0] i_AluRd,
  input  logic [DATA_WIDTH-1:0]     i_AluData,
  output logic                      o_AluReady,
  input  logic                      i_LoadValid,
  input  logic [REG_ADDR_WIDTH-1:0] i_LoadRd,
  input  logic [DATA_WIDTH-1:0]     i_LoadData,
  output logic                      o_LoadReady,
  input  logic                      i_IssueValid,
  input  logic [REG_ADDR_WIDTH-1:0] i_IssueRd,
  input  logic [REG_ADDR_WIDTH-1:0] i_RegSource1,
  input  logic [REG_ADDR_WIDTH-1:0] i_RegSource2,
  output logic                      o_Busy1,
  output logic                      o_Busy2,
  output logic                      o_WriteEnable,
  output logic [REG_ADDR_WIDTH-1:0] o_RegDest,
  output logic [DATA_WIDTH-1:0]     o_DataOut
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(REG_ZERO);

  logic                      aluGrant;
  logic                      loadGrant;
  logic                      transfer;
  logic [REG_ADDR_WIDTH-1:0] grantedRd;
  logic [DATA_WIDTH-1:0]     grantedData;
  logic [NUM_REGS-1:0]       scoreboard;
  logic [NUM_REGS-1:0]       scoreboardNext;

  // Requests are masked during reset so nothing is granted in that cycle
  rr_arbiter2 u_arbiter (
    .i_Clock        (i_Clock),
    .i_Reset        (i_Reset),
    .i_AluReq       (i_AluValid & ~i_Reset),
    .i_LoadReq      (i_LoadValid & ~i_Reset),
    .i_LoadPriority (LOAD_PRIORITY != 0),
    .o_AluGrant     (aluGrant),
    .o_LoadGrant    (loadGrant)
  );

  assign o_AluReady  = aluGrant;
  assign o_LoadReady = loadGrant;
  assign transfer    = aluGrant | loadGrant;
  assign grantedRd   = loadGrant ? i_LoadRd : i_AluRd;
  assign grantedData = loadGrant ? i_LoadData : i_AluData;

  // Load acceptance clears its pending bit first so a same-cycle issue to that register re-sets it
  always_comb begin
    scoreboardNext = scoreboard;
    if (loadGrant && (i_LoadRd != ZERO_IDX)) begin
      scoreboardNext[i_LoadRd] = 1'b0;
    end
    if (i_IssueValid && (i_IssueRd != ZERO_IDX)) begin
      scoreboardNext[i_IssueRd] = 1'b1;
    end
    scoreboardNext[0] = 1'b0;
  end

  // Pending-load scoreboard, wiped on reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      scoreboard <= '0;
    end else begin
      scoreboard <= scoreboardNext;
    end
  end

  // Register-file write stage; writes to x0 complete the handshake but never assert the enable
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_WriteEnable <= 1'b0;
      o_RegDest     <= '0;
      o_DataOut     <= '0;
    end else begin
      o_WriteEnable <= transfer && (grantedRd != ZERO_IDX);
      if (transfer && (grantedRd != ZERO_IDX)) begin
        o_RegDest <= grantedRd;
        o_DataOut <= grantedData;
      end
    end
  end

  // A source is busy while its load is outstanding, or while its value is in the write pipeline
  always_comb begin
    o_Busy1 = (i_RegSource1 != ZERO_IDX) &&
              (scoreboard[i_RegSource1] ||
               (o_WriteEnable && (o_RegDest == i_RegSource1)) ||
               (transfer && (grantedRd == i_RegSource1)));
    o_Busy2 = (i_RegSource2 != ZERO_IDX) &&
              (scoreboard[i_RegSource2] ||
               (o_WriteEnable && (o_RegDest == i_RegSource2)) ||
               (transfer && (grantedRd == i_RegSource2)));
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid, loadValid, issueValid;
  logic [4:0]  aluRd, loadRd, issueRd, src1, src2;
  logic [31:0] aluData, loadData;

  logic        aluReady, loadReady, busy1, busy2, we;
  logic [4:0]  regDest;
  logic [31:0] dataOut;

  logic        aluReadyP, loadReadyP, busy1P, busy2P, weP;
  logic [4:0]  regDestP;
  logic [31:0] dataOutP;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_PRIORITY(0)) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_AluValid(aluValid), .i_AluRd(aluRd), .i_AluData(aluData), .o_AluReady(aluReady),
    .i_LoadValid(loadValid), .i_LoadRd(loadRd), .i_LoadData(loadData), .o_LoadReady(loadReady),
    .i_IssueValid(issueValid), .i_IssueRd(issueRd),
    .i_RegSource1(src1), .i_RegSource2(src2), .o_Busy1(busy1), .o_Busy2(busy2),
    .o_WriteEnable(we), .o_RegDest(regDest), .o_DataOut(dataOut)
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .LOAD_PRIORITY(1)) dutPrio (
    .i_Clock(clk), .i_Reset(rst),
    .i_AluValid(aluValid), .i_AluRd(aluRd), .i_AluData(aluData), .o_AluReady(aluReadyP),
    .i_LoadValid(loadValid), .i_LoadRd(loadRd), .i_LoadData(loadData), .o_LoadReady(loadReadyP),
    .i_IssueValid(issueValid), .i_IssueRd(issueRd),
    .i_RegSource1(src1), .i_RegSource2(src2), .o_Busy1(busy1P), .o_Busy2(busy2P),
    .o_WriteEnable(weP), .o_RegDest(regDestP), .o_DataOut(dataOutP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    aluValid = 1'b0; aluRd = '0; aluData = '0;
    loadValid = 1'b0; loadRd = '0; loadData = '0;
    issueValid = 1'b0; issueRd = '0;
    src1 = 5'd7; src2 = 5'd0;
    tick();
    tick();
    chk("rst_we", we, 0);
    chk("rst_dest", regDest, 0);
    chk("rst_data", dataOut, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;

    // ALU alone, Rd=5
    aluValid = 1'b1; aluRd = 5'd5; aluData = 32'hDEADBEEF; src1 = 5'd5;
    #1;
    chk("t1_aluReady", aluReady, 1);
    chk("t1_loadReady", loadReady, 0);
    tick();
    aluValid = 1'b0;
    #1;
    chk("t1_we", we, 1);
    chk("t1_dest", regDest, 5);
    chk("t1_data", dataOut, 32'hDEADBEEF);
    chk("t1_busy_wb", busy1, 1);
    tick();
    chk("t1_we_off", we, 0);
    chk("t1_dest_hold", regDest, 5);
    chk("t1_busy_clear", busy1, 0);

    // Four contended cycles: round-robin L,A,L,A; priority instance always L
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'h33;
    loadValid = 1'b1; loadRd = 5'd4; loadData = 32'h44;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_loadReady", loadReady, (i % 2 == 0) ? 1 : 0);
      chk("t2_aluReady", aluReady, (i % 2 == 0) ? 0 : 1);
      chk("t2p_loadReady", loadReadyP, 1);
      chk("t2p_aluReady", aluReadyP, 0);
      tick();
      chk("t2_dest", regDest, (i % 2 == 0) ? 4 : 3);
    end
    aluValid = 1'b0; loadValid = 1'b0;
    tick();

    // Load issued to x7, returned later
    issueValid = 1'b1; issueRd = 5'd7; src1 = 5'd7; src2 = 5'd7;
    #1;
    chk("t3_busy_pre", busy1, 0);
    tick();
    issueValid = 1'b0;
    #1;
    chk("t3_busy_pend", busy1, 1);
    chk("t3_busy2_pend", busy2, 1);
    tick();
    chk("t3_busy_hold", busy1, 1);
    loadValid = 1'b1; loadRd = 5'd7; loadData = 32'h77;
    #1;
    chk("t3_loadReady", loadReady, 1);
    chk("t3_busy_xfer", busy1, 1);
    tick();
    loadValid = 1'b0;
    #1;
    chk("t3_busy_wb", busy1, 1);
    chk("t3_we", we, 1);
    chk("t3_dest", regDest, 7);
    chk("t3_data", dataOut, 32'h77);
    tick();
    chk("t3_busy_done", busy1, 0);
    chk("t3_busy2_done", busy2, 0);

    // Writes and issues to x0
    src2 = 5'd0;
    aluValid = 1'b1; aluRd = 5'd0; aluData = 32'h1;
    #1;
    chk("t4_aluReady", aluReady, 1);
    tick();
    aluValid = 1'b0;
    #1;
    chk("t4_we", we, 0);
    issueValid = 1'b1; issueRd = 5'd0; src1 = 5'd0;
    tick();
    issueValid = 1'b0;
    #1;
    chk("t4_busy_x0", busy1, 0);

    // Issue and return of x9 in the same cycle: pending bit must survive
    issueValid = 1'b1; issueRd = 5'd9; loadValid = 1'b1; loadRd = 5'd9; loadData = 32'h99; src1 = 5'd9;
    #1;
    chk("t5_loadReady", loadReady, 1);
    chk("t5_busy_xfer", busy1, 1);
    tick();
    issueValid = 1'b0; loadValid = 1'b0;
    #1;
    chk("t5_busy_wb", busy1, 1);
    tick();
    chk("t5_sb_set", busy1, 1);

    // Contention won by load, then reset while the write is in the output stage
    aluValid = 1'b1; aluRd = 5'd3; aluData = 32'hA3;
    loadValid = 1'b1; loadRd = 5'd12; loadData = 32'hC12; src2 = 5'd3;
    #1;
    chk("t6_pre_load", loadReady, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_alu", aluReady, 0);
    chk("t6_rst_load", loadReady, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_we", we, 0);
    chk("t6_busy1", busy1, 0);
    chk("t6_busy2", busy2, 0);
    chk("t6_ptr_load", loadReady, 1);
    chk("t6_ptr_alu", aluReady, 0);
    aluValid = 1'b0; loadValid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
